// File: rtl/debug_reg_dumper.sv
// Debug register dumper: reads every register through the debug read port and streams
// its bytes LSB-first over a valid/ready byte interface. DEBUG_REG_DUMPER_CHECKSUM_EN appends an XOR byte.
module debug_reg_dumper #(
    parameter int unsigned NB_DATA  = 32,
    parameter int unsigned NB_REG   = 5,
    parameter int unsigned SIZE_REG = 32,
    parameter int unsigned NB_BYTE  = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [NB_REG-1:0]  o_address_read_debug,
    input  logic [NB_DATA-1:0] i_data_read_debug,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned NB_WORD_BYTES = NB_DATA / NB_BYTE;
    localparam int unsigned NB_CNT        = $clog2(NB_WORD_BYTES + 1);
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_WORD_BYTES - 1);
    localparam logic [NB_REG-1:0] LAST_REG  = NB_REG'(SIZE_REG - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StSend,
`ifdef DEBUG_REG_DUMPER_CHECKSUM_EN
        StCksum,
`endif
        StDone
    } state_e;

    state_e             state_q;
    logic [NB_REG-1:0]  addr_q;
    logic [NB_DATA-1:0] shift_q;
    logic [NB_CNT-1:0]  cnt_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
`ifdef DEBUG_REG_DUMPER_CHECKSUM_EN
    logic [NB_BYTE-1:0] cksum_q;
`endif

    logic [NB_BYTE-1:0] tx_byte;
    assign tx_byte = shift_q[NB_BYTE-1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DEBUG_REG_DUMPER_CHECKSUM_EN
            cksum_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q <= StRead;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
`ifdef DEBUG_REG_DUMPER_CHECKSUM_EN
                        cksum_q <= '0;
`endif
                    end
                end
                StRead: begin
                    // Each word is sampled exactly once, here.
                    shift_q <= i_data_read_debug;
                    cnt_q   <= '0;
                    valid_q <= 1'b1;
                    state_q <= StSend;
                end
                StSend: begin
                    if (i_tx_ready) begin
                        shift_q <= shift_q >> NB_BYTE;
                        cnt_q   <= cnt_q + NB_CNT'(1);
`ifdef DEBUG_REG_DUMPER_CHECKSUM_EN
                        cksum_q <= cksum_q ^ tx_byte;
`endif
                        if (cnt_q == LAST_BYTE) begin
                            valid_q <= 1'b0;
                            if (addr_q == LAST_REG) begin
`ifdef DEBUG_REG_DUMPER_CHECKSUM_EN
                                // Checksum rides out through the shift register's low byte.
                                shift_q <= NB_DATA'(cksum_q ^ tx_byte);
                                valid_q <= 1'b1;
                                state_q <= StCksum;
`else
                                done_q  <= 1'b1;
                                state_q <= StDone;
`endif
                            end else begin
                                addr_q  <= addr_q + NB_REG'(1);
                                state_q <= StRead;
                            end
                        end
                    end
                end
`ifdef DEBUG_REG_DUMPER_CHECKSUM_EN
                StCksum: begin
                    if (i_tx_ready) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
`endif
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_address_read_debug = addr_q;
    assign o_tx_data            = tx_byte;
    assign o_tx_valid           = valid_q;
    assign o_busy               = busy_q;
    assign o_done               = done_q;

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Randomized bench for debug_reg_dumper: a byte-stream model built from a register
// snapshot is checked every cycle against the DUT handshake, address and status outputs.
module tb_debug_reg_dumper;

    localparam int NREG = 32;
    localparam int NBPW = 4;
`ifdef DEBUG_REG_DUMPER_CHECKSUM_EN
    localparam int NTOT       = NREG * NBPW + 1;
    localparam int DONE_EDGES = 161;
`else
    localparam int NTOT       = NREG * NBPW;
    localparam int DONE_EDGES = 160;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [4:0]  o_address_read_debug;
    logic [31:0] i_data_read_debug;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic        o_busy;
    logic        o_done;

    logic [31:0] regs [NREG];
    assign i_data_read_debug = regs[o_address_read_debug];

    debug_reg_dumper dut (
        .i_clk                (i_clk),
        .i_reset              (i_reset),
        .i_start              (i_start),
        .o_address_read_debug (o_address_read_debug),
        .i_data_read_debug    (i_data_read_debug),
        .o_tx_data            (o_tx_data),
        .o_tx_valid           (o_tx_valid),
        .i_tx_ready           (i_tx_ready),
        .o_busy               (o_busy),
        .o_done               (o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc++;

    // Model state
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] ref_q[$];
    logic       model_busy = 1'b0;
    logic       done_next = 1'b0;
    logic       drop_next = 1'b0;
    int         done_count = 0;
    int         done_cyc = 0;
    int         start_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = '0;
    logic       rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(posedge i_clk) begin
        #1 i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge i_clk) begin
        if (i_reset) begin
            prev_valid = 1'b0;
        end else begin
            int idx;
            int exp_addr;
            logic [7:0] e;
            if (drop_next) begin
                model_busy = 1'b0;
                drop_next  = 1'b0;
            end
            check("busy", o_busy, model_busy);
            check("done", o_done, done_next);
            done_next = 1'b0;
            if (o_done) begin
                done_count++;
                done_cyc  = cyc;
                drop_next = 1'b1;
            end
            if (!model_busy) check("idle_valid", o_tx_valid, 1'b0);
            if (prev_valid && !prev_ready) begin
                check("stall_valid", o_tx_valid, 1'b1);
                check("stall_data", o_tx_data, prev_data);
            end
            if (o_tx_valid && i_tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_byte: got %0h, expected no byte", o_tx_data);
                end else begin
                    idx      = NTOT - exp_q.size();
                    exp_addr = (idx / NBPW > NREG - 1) ? NREG - 1 : idx / NBPW;
                    e        = exp_q.pop_front();
                    check("byte", o_tx_data, e);
                    check("addr", o_address_read_debug, exp_addr);
                    got_q.push_back(o_tx_data);
                    if (exp_q.size() == 0) done_next = 1'b1;
                end
            end
            prev_valid = o_tx_valid;
            prev_ready = i_tx_ready;
            prev_data  = o_tx_data;
        end
    end

    task automatic start_dump();
        logic [7:0] ck;
        @(posedge i_clk);
        #1 i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        if (!model_busy) begin
            exp_q.delete();
            got_q.delete();
            ck = '0;
            for (int r = 0; r < NREG; r++) begin
                for (int b = 0; b < NBPW; b++) begin
                    exp_q.push_back(regs[r][8*b +: 8]);
                    ck ^= regs[r][8*b +: 8];
                end
            end
`ifdef DEBUG_REG_DUMPER_CHECKSUM_EN
            exp_q.push_back(ck);
`endif
            model_busy = 1'b1;
            start_cyc  = cyc;
        end
    endtask

    task automatic wait_done(input int budget);
        int base;
        int n;
        base = done_count;
        n    = 0;
        while (done_count == base && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        if (done_count == base) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no o_done, expected one within %0d cycles", budget);
        end
        repeat (3) @(posedge i_clk);
    endtask

    task automatic wait_bytes(input int count, input int budget);
        int n;
        n = 0;
        while (got_q.size() < count && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        if (got_q.size() < count) begin
            n_checks++;
            n_errors++;
            $display("FAIL bytes_timeout: got %0d bytes, expected %0d", got_q.size(), count);
        end
    endtask

    task automatic set_pattern();
        for (int r = 0; r < NREG; r++) regs[r] = 32'h1122_3300 + r;
    endtask

    initial begin
        int base;
        int bad;
        set_pattern();
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;

        // Idle after reset
        repeat (20) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_valid", o_tx_valid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_addr", o_address_read_debug, 5'd0);

        // Full dump, ready held high
        base = done_count;
        start_dump();
        @(negedge i_clk);
        check("read_bubble_valid", o_tx_valid, 1'b0);
        @(negedge i_clk);
        check("first_valid", o_tx_valid, 1'b1);
        check("first_byte", o_tx_data, 8'h00);
        wait_done(400);
        check("t2_len", got_q.size(), NTOT);
        check("t2_b0", got_q[0], 8'h00);
        check("t2_b1", got_q[1], 8'h33);
        check("t2_b2", got_q[2], 8'h22);
        check("t2_b3", got_q[3], 8'h11);
        check("t2_b124", got_q[124], 8'h1F);
        check("t2_b127", got_q[127], 8'h11);
`ifdef DEBUG_REG_DUMPER_CHECKSUM_EN
        check("t2_cksum", got_q[128], 8'h00);
`endif
        check("t2_done_count", done_count - base, 1);
        check("t2_latency", done_cyc - start_cyc, DONE_EDGES);
        ref_q = got_q;

        // Random backpressure, same data
        rand_ready = 1'b1;
        start_dump();
        wait_done(2000);
        check("t3_len", got_q.size(), ref_q.size());
        bad = 0;
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            if (got_q[i] !== ref_q[i]) bad++;
        check("t3_bytes_match", bad, 0);

        // Ignored restart, then reset mid-dump
        base = done_count;
        start_dump();
        wait_bytes(50, 2000);
        start_dump();
        wait_bytes(70, 2000);
        #3 i_reset = 1'b1;
        #1;
        check("abort_valid", o_tx_valid, 1'b0);
        check("abort_busy", o_busy, 1'b0);
        check("abort_done", o_done, 1'b0);
        check("abort_addr", o_address_read_debug, 5'd0);
        check("abort_data", o_tx_data, 8'h00);
        check("t4_done_count", done_count - base, 0);
        exp_q.delete();
        model_busy = 1'b0;
        done_next  = 1'b0;
        drop_next  = 1'b0;
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        rand_ready = 1'b0;
        base = done_count;
        start_dump();
        wait_done(400);
        check("t4_len", got_q.size(), NTOT);
        check("t4_b0", got_q[0], 8'h00);
        check("t4_b3", got_q[3], 8'h11);
        check("t4_done_count2", done_count - base, 1);

        // Register changes after its read cycle
        regs[5] = 32'hAAAA_0005;
        rand_ready = 1'b1;
        start_dump();
        wait_bytes(21, 2000);
        regs[5] = 32'hBBBB_0005;
        wait_done(2000);
        check("t5_b20", got_q[20], 8'h05);
        check("t5_b21", got_q[21], 8'h00);
        check("t5_b22", got_q[22], 8'hAA);
        check("t5_b23", got_q[23], 8'hAA);
        rand_ready = 1'b0;

`ifdef DEBUG_REG_DUMPER_CHECKSUM_EN
        for (int r = 0; r < NREG; r++) regs[r] = '0;
        regs[0] = 32'h0000_0001;
        start_dump();
        wait_done(400);
        check("t6_len", got_q.size(), NTOT);
        check("t6_cksum", got_q[NTOT-1], 8'h01);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
